// File: rtl/rx_vote_n.sv
// rx_vote_n: N-copy majority receiver. Copies of a frame are grouped by their
// sequence-ID byte and stored in MAX_COPIES+1 slots. Once the last copy's ID
// is seen, a bitwise-majority frame is streamed out while that copy is still
// arriving.
module rx_vote_n #(
  parameter int unsigned MAX_COPIES = 5,
  parameter int unsigned MAX_LEN    = 1536,
  parameter int unsigned ID_OFFSET  = 34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] copies_sel,
  input  logic       in_en,
  input  logic [7:0] in_data,
  output logic       out_en,
  output logic [7:0] out_data,
  output logic       lost,
  output logic       corrected
);

  localparam int unsigned NS  = MAX_COPIES + 1;
  localparam int unsigned IW  = $clog2(NS);
  localparam int unsigned AW  = $clog2(MAX_LEN + 1);
  localparam int unsigned AIW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HDR, BODY, DROP} rx_state_t;
  typedef enum logic {E_IDLE, E_RUN} em_state_t;

  function automatic logic [IW-1:0] wrap(input int unsigned x);
    return IW'((x >= NS) ? x - NS : x);
  endfunction

  rx_state_t       state, state_nx;
  em_state_t       e_state, e_state_nx;

  logic [7:0]      mem [NS][MAX_LEN];
  logic [AW-1:0]   len [NS];

  logic [IW-1:0]   base, cnt, wslot;
  logic [AW-1:0]   wptr;
  logic [2:0]      r_lat;
  logic [7:0]      grp_id, last_id;
  logic            have_prev;

  logic [IW-1:0]   e_base, e_last;
  logic [2:0]      e_r;
  logic [AW-1:0]   rptr;
  logic            dis_acc;

  logic            acc, id_at, id_hit, mism, done, gap, more, dis;
  logic [AW-1:0]   bidx;
  logic [IW-1:0]   cur_slot, eff_cnt, eff_base;
  logic [7:0]      eff_id, vote;
  logic [2:0]      r_cur;

  // Per-byte receive decode: which slot/index is written and the ID-byte checks
  always_comb begin
    bidx     = (state == IDLE) ? '0 : wptr;
    cur_slot = (state == IDLE) ? wrap(32'(base) + 32'(cnt)) : wslot;
    r_cur    = (state == IDLE && cnt == '0) ? copies_sel : r_lat;
    acc      = in_en && ((state == IDLE && (cnt != '0 ||
                 (copies_sel[0] && 32'(copies_sel) <= MAX_COPIES))) ||
                 state == HDR || state == BODY);
    id_at    = (32'(bidx) == ID_OFFSET);
    id_hit   = acc && (state != BODY) && id_at;
    mism     = id_hit && (cnt != '0) && (in_data != grp_id);
    eff_cnt  = mism ? '0 : cnt;
    eff_base = mism ? cur_slot : base;
    eff_id   = (cnt == '0 || mism) ? in_data : grp_id;
    done     = id_hit && (32'(eff_cnt) + 1 == 32'(r_cur));
    gap      = done && have_prev && (eff_id != last_id + 8'd1);
  end

  // Receive FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Receive FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_en) state_nx = !acc ? DROP : (id_at ? BODY : HDR);
      HDR:  if (!in_en) state_nx = IDLE;
            else if (id_at) state_nx = BODY;
      BODY: if (!in_en) state_nx = IDLE;
      DROP: if (!in_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Payload storage; bytes past MAX_LEN are not kept
  always_ff @(posedge clk) begin
    if (acc && 32'(bidx) < MAX_LEN) mem[cur_slot][AIW'(bidx)] <= in_data;
  end

  // Group bookkeeping: lengths, slot base/count, IDs, lost pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NS; i++) len[IW'(i)] <= '0;
      base <= '0; cnt <= '0; wslot <= '0; wptr <= '0; r_lat <= '0;
      grp_id <= '0; last_id <= '0; have_prev <= 1'b0; lost <= 1'b0;
      e_base <= '0; e_last <= '0; e_r <= '0;
    end else begin
      lost <= mism | gap;
      if (acc) begin
        wslot <= cur_slot;
        if (32'(bidx) < MAX_LEN) begin
          len[cur_slot] <= bidx + AW'(1);
          wptr          <= bidx + AW'(1);
        end
        if (state == IDLE && cnt == '0) r_lat <= copies_sel;
      end
      if (id_hit) begin
        grp_id <= eff_id;
        if (done) begin
          base      <= wrap(32'(eff_base) + 32'(r_cur));
          cnt       <= '0;
          last_id   <= eff_id;
          have_prev <= 1'b1;
          e_base    <= eff_base;
          e_r       <= r_cur;
          e_last    <= cur_slot;
        end else begin
          base <= eff_base;
          cnt  <= IW'(32'(eff_cnt) + 1);
        end
      end
    end
  end

  // Bitwise majority over the group's copies; short copies contribute zeros
  always_comb begin : vote_blk
    int unsigned ones;
    logic [IW-1:0] s;
    vote = '0;
    dis  = 1'b0;
    ones = 0;
    s    = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      ones = 0;
      for (int unsigned k = 0; k < MAX_COPIES; k++) begin
        if (k < 32'(e_r)) begin
          s = wrap(32'(e_base) + k);
          if (rptr < len[s] && mem[s][AIW'(rptr)][3'(b)]) ones++;
        end
      end
      vote[3'(b)] = (ones > 32'(e_r) / 2);
      if (ones != 0 && ones != 32'(e_r)) dis = 1'b1;
    end
  end

  // Live length of the last copy bounds the output frame
  assign more = (rptr < len[e_last]);

  // Emitter FSM state register
  always_ff @(posedge clk) begin
    if (rst) e_state <= E_IDLE;
    else     e_state <= e_state_nx;
  end

  // Emitter FSM next state
  always_comb begin
    e_state_nx = e_state;
    case (e_state)
      E_IDLE: if (done) e_state_nx = E_RUN;
      E_RUN:  if (!done && !more) e_state_nx = E_IDLE;
      default: e_state_nx = E_IDLE;
    endcase
  end

  // Emitter datapath: stream voted bytes, flag disagreement after the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0; out_en <= 1'b0; out_data <= '0;
      corrected <= 1'b0; dis_acc <= 1'b0;
    end else begin
      corrected <= 1'b0;
      if (done) begin
        rptr    <= '0;
        dis_acc <= 1'b0;
        out_en  <= 1'b0;
      end else if (e_state == E_RUN) begin
        if (more) begin
          out_en   <= 1'b1;
          out_data <= vote;
          rptr     <= rptr + AW'(1);
          dis_acc  <= dis_acc | dis;
        end else begin
          out_en    <= 1'b0;
          corrected <= dis_acc;
        end
      end
    end
  end

endmodule
